// File: rtl/pipe_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline control logic:
// forwarding-mux select codes, controller state encodings and the
// default register-address width.
package pipe_pkg;

  localparam int REG_AW_DEF = 5;

  // Select codes for the 3-input EX-stage operand muxes
  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MD_WAIT    = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/md_busy_ctr.sv
// Busy tracker for the multi-cycle mult/div unit. A start loads
// LATENCY-1; the count then falls by one per cycle and the unit is
// busy while it is nonzero. A start while busy restarts the count.
module md_busy_ctr #(
  parameter int LATENCY = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy
);

  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;

  logic [CW-1:0] count_q;

  // Countdown register: reload on start, otherwise decrement toward zero
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (rst) begin
      count_q <= '0;
    end else if (start) begin
      count_q <= CW'(LATENCY - 1);
    end else if (count_q != '0) begin
      count_q <= count_q - CW'(1);
    end
  end

  assign busy = (count_q != '0);

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Pipeline hazard and forwarding controller for the 5-stage MIPS core.
// Produces the registered EX-stage operand forwarding selects, the
// PC / IF/ID / ID/EX stall and flush controls, and interlocks HI/LO
// readers against the multi-cycle mult/div unit.
// Optional build macro HAZARD_PERF_EN adds stall_cycles / flush_count
// performance counters as extra outputs.
module hazard_fwd_ctrl
  import pipe_pkg::*;
#(
  parameter int MD_LATENCY = 32,
  parameter int REG_AW     = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_use_hilo,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic              ex_branch_taken,
  input  logic              md_start,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              pc_stall,
  output logic              ifid_stall,
  output logic              ifid_flush,
  output logic              idex_flush,
`ifdef HAZARD_PERF_EN
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_count,
`endif
  output logic              md_busy
);

  ctrl_state_e state_q, state_d;
  logic [1:0]  fwd_a_q, fwd_b_q;
  logic        load_use;

  // Forward select for one ID source operand. The EX producer wins over
  // MEM because it is the younger write; a load still in EX has no data
  // yet, so it is left to the load-use stall instead. $0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic              use_src,
    input logic [REG_AW-1:0] src,
    input logic [REG_AW-1:0] e_rd,
    input logic              e_rw,
    input logic              e_mr,
    input logic [REG_AW-1:0] m_rd,
    input logic              m_rw
  );
    logic [1:0] sel;
    sel = FWD_REG;
    if (use_src) begin
      if (e_rw && (e_rd != '0) && (e_rd == src) && !e_mr) begin
        sel = FWD_EXMEM;
      end else if (m_rw && (m_rd != '0) && (m_rd == src)) begin
        sel = FWD_MEMWB;
      end
    end
    return sel;
  endfunction

  assign load_use = ex_memread && (ex_rd != '0) &&
                    ((id_use_rs && (ex_rd == id_rs)) ||
                     (id_use_rt && (ex_rd == id_rt)));

  md_busy_ctr #(
    .LATENCY (MD_LATENCY)
  ) u_md_busy_ctr (
    .clk   (clk),
    .rst   (rst),
    .start (md_start),
    .busy  (md_busy)
  );

  // Next state and stall/flush controls; a taken branch overrides any stall
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    pc_stall   = 1'b0;
    ifid_stall = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (ex_branch_taken) begin
      // The stalled ID instruction is on the wrong path: squash it
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      state_d    = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (load_use) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
            state_d    = LOAD_STALL;
          end else if (id_use_hilo && md_busy) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
            state_d    = MD_WAIT;
          end
        end
        LOAD_STALL: begin
          // One bubble is enough: the load has moved on to MEM
          state_d = RUN;
        end
        MD_WAIT: begin
          if (md_busy) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Controller state and forwarding selects, captured as ID moves to EX
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      fwd_a_q <= FWD_REG;
      fwd_b_q <= FWD_REG;
    end else begin
      state_q <= state_d;
      if (idex_flush) begin
        // A bubble enters EX, so it must not pull forwarded operands
        fwd_a_q <= FWD_REG;
        fwd_b_q <= FWD_REG;
      end else begin
        fwd_a_q <= fwd_sel(id_use_rs, id_rs, ex_rd, ex_regwrite, ex_memread,
                           mem_rd, mem_regwrite);
        fwd_b_q <= fwd_sel(id_use_rt, id_rt, ex_rd, ex_regwrite, ex_memread,
                           mem_rd, mem_regwrite);
      end
    end
  end

  assign fwd_a = fwd_a_q;
  assign fwd_b = fwd_b_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles_q, flush_count_q;

  // Performance counters: cycles spent holding PC and IF/ID flushes seen
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (pc_stall)   stall_cycles_q <= stall_cycles_q + 32'd1;
      if (ifid_flush) flush_count_q  <= flush_count_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl (MD_LATENCY=4). Inputs change on the
// falling edge; combinational controls are sampled 1ns later and the
// registered selects on the following falling edge.
module tb_hazard_fwd_ctrl;

  localparam int REG_AW = 5;

  logic              clk;
  logic              rst;
  logic [REG_AW-1:0] id_rs, id_rt, ex_rd, mem_rd;
  logic              id_use_rs, id_use_rt, id_use_hilo;
  logic              ex_regwrite, ex_memread, mem_regwrite;
  logic              ex_branch_taken, md_start;
  logic [1:0]        fwd_a, fwd_b;
  logic              pc_stall, ifid_stall, ifid_flush, idex_flush, md_busy;
`ifdef HAZARD_PERF_EN
  logic [31:0]       stall_cycles, flush_count;
`endif

  int checks   = 0;
  int failures = 0;
  int stall_n;

  hazard_fwd_ctrl #(
    .MD_LATENCY (4),
    .REG_AW     (REG_AW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_use_rs       (id_use_rs),
    .id_use_rt       (id_use_rt),
    .id_use_hilo     (id_use_hilo),
    .ex_rd           (ex_rd),
    .ex_regwrite     (ex_regwrite),
    .ex_memread      (ex_memread),
    .mem_rd          (mem_rd),
    .mem_regwrite    (mem_regwrite),
    .ex_branch_taken (ex_branch_taken),
    .md_start        (md_start),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .pc_stall        (pc_stall),
    .ifid_stall      (ifid_stall),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
`ifdef HAZARD_PERF_EN
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count),
`endif
    .md_busy         (md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    id_use_hilo = 1'b0;
    ex_rd = '0; ex_regwrite = 1'b0; ex_memread = 1'b0;
    mem_rd = '0; mem_regwrite = 1'b0;
    ex_branch_taken = 1'b0; md_start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_fwd_a"},      32'(fwd_a),      32'd0);
    check({tag, "_fwd_b"},      32'(fwd_b),      32'd0);
    check({tag, "_pc_stall"},   32'(pc_stall),   32'd0);
    check({tag, "_ifid_stall"}, 32'(ifid_stall), 32'd0);
    check({tag, "_ifid_flush"}, 32'(ifid_flush), 32'd0);
    check({tag, "_idex_flush"}, 32'(idex_flush), 32'd0);
    check({tag, "_md_busy"},    32'(md_busy),    32'd0);
`ifdef HAZARD_PERF_EN
    check({tag, "_stall_cycles"}, stall_cycles, 32'd0);
    check({tag, "_flush_count"},  flush_count,  32'd0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all_zero("reset");

    // EX producer $3, ID reads rs=3 -> 01 next cycle
    @(negedge clk);
    idle(); ex_rd = 5'd3; ex_regwrite = 1'b1; id_rs = 5'd3; id_use_rs = 1'b1;
    #1 check("ex_fwd_no_stall", 32'(pc_stall), 32'd0);
    // MEM producer $3 only -> 10
    @(negedge clk);
    check("ex_fwd_a", 32'(fwd_a), 32'd1);
    check("ex_fwd_b", 32'(fwd_b), 32'd0);
    idle(); mem_rd = 5'd3; mem_regwrite = 1'b1; id_rs = 5'd3; id_use_rs = 1'b1;
    // Register 0 in both stages -> 00
    @(negedge clk);
    check("mem_fwd_a", 32'(fwd_a), 32'd2);
    idle(); ex_rd = 5'd0; ex_regwrite = 1'b1; mem_rd = 5'd0; mem_regwrite = 1'b1;
    id_rs = 5'd0; id_use_rs = 1'b1;
    // Match present but rs not used -> 00
    @(negedge clk);
    check("r0_fwd_a", 32'(fwd_a), 32'd0);
    idle(); ex_rd = 5'd3; ex_regwrite = 1'b1; id_rs = 5'd3; id_use_rs = 1'b0;
    // EX and MEM both write $5, rs=rt=5 -> EX wins on both
    @(negedge clk);
    check("unused_fwd_a", 32'(fwd_a), 32'd0);
    idle(); ex_rd = 5'd5; ex_regwrite = 1'b1; mem_rd = 5'd5; mem_regwrite = 1'b1;
    id_rs = 5'd5; id_rt = 5'd5; id_use_rs = 1'b1; id_use_rt = 1'b1;
    @(negedge clk);
    check("prio_fwd_a", 32'(fwd_a), 32'd1);
    check("prio_fwd_b", 32'(fwd_b), 32'd1);

    // Load $4 in EX, ID reads rt=4 -> one stall cycle, then fwd_b=10
    idle(); ex_rd = 5'd4; ex_regwrite = 1'b1; ex_memread = 1'b1;
    id_rs = 5'd9; id_use_rs = 1'b1; id_rt = 5'd4; id_use_rt = 1'b1;
    #1;
    check("lu_pc_stall",   32'(pc_stall),   32'd1);
    check("lu_ifid_stall", 32'(ifid_stall), 32'd1);
    check("lu_idex_flush", 32'(idex_flush), 32'd1);
    check("lu_ifid_flush", 32'(ifid_flush), 32'd0);
    @(negedge clk);
    check("lu_bubble_fwd_b", 32'(fwd_b), 32'd0);
    ex_rd = 5'd0; ex_regwrite = 1'b0; ex_memread = 1'b0;
    mem_rd = 5'd4; mem_regwrite = 1'b1;
    #1 check("lu_second_no_stall", 32'(pc_stall), 32'd0);
    @(negedge clk);
    check("lu_fwd_b", 32'(fwd_b), 32'd2);
    check("lu_fwd_a", 32'(fwd_a), 32'd0);
    idle();
    #1 check("lu_after_no_stall", 32'(pc_stall), 32'd0);

    // mult/div start, mfhi in ID one cycle later -> 3 stalled cycles
    @(negedge clk);
    idle(); md_start = 1'b1;
    @(negedge clk);
    md_start = 1'b0; id_use_hilo = 1'b1;
    #1;
    check("md_busy_entry", 32'(md_busy), 32'd1);
    check("md_idex_flush_entry", 32'(idex_flush), 32'd1);
    stall_n = 0;
    for (int i = 0; i < 8; i++) begin
      if (pc_stall) stall_n++;
      @(negedge clk);
      #1;
    end
    check("md_stall_count", 32'(stall_n), 32'd3);
    check("md_busy_done", 32'(md_busy), 32'd0);
    check("md_no_stall_done", 32'(pc_stall), 32'd0);

    // Load-use together with a taken branch -> flush wins, state RUN
    @(negedge clk);
    idle(); ex_rd = 5'd4; ex_regwrite = 1'b1; ex_memread = 1'b1;
    id_rt = 5'd4; id_use_rt = 1'b1; ex_branch_taken = 1'b1;
    #1;
    check("br_ifid_flush", 32'(ifid_flush), 32'd1);
    check("br_idex_flush", 32'(idex_flush), 32'd1);
    check("br_pc_stall",   32'(pc_stall),   32'd0);
    check("br_ifid_stall", 32'(ifid_stall), 32'd0);
    // Still in RUN: the same hazard must stall immediately
    @(negedge clk);
    check("br_fwd_b_cleared", 32'(fwd_b), 32'd0);
    ex_branch_taken = 1'b0;
    #1 check("br_then_run_stall", 32'(pc_stall), 32'd1);

    // Reset while waiting on mult/div
    @(negedge clk);
    idle(); md_start = 1'b1;
    @(negedge clk);
    md_start = 1'b0; id_use_hilo = 1'b1;
    #1 check("rst_pre_stall", 32'(pc_stall), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    idle(); ex_rd = 5'd3; ex_regwrite = 1'b1; id_rs = 5'd3; id_use_rs = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle();
    #1 check_all_zero("mid_rst");

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
- Pipeline controller for the 5-stage MIPS core.
- Drives the select inputs of the two EX-stage operand forwarding muxes (3-input; 00 regfile, 01 EX/MEM, 10 MEM/WB).
- Generates stall and flush controls for PC, IF/ID and ID/EX.
- Sequences a multi-cycle mult/div unit, including its busy interlock.

Parameters:
- MD_LATENCY, 32, cycles the mult/div unit stays busy after md_start (≥2).
- REG_AW, 5, register-address width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- id_rs  in  REG_AW  ID-stage rs
- id_rt  in  REG_AW  ID-stage rt
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- id_use_hilo  in  1  ID instruction reads HI/LO (mfhi/mflo)
- ex_rd  in  REG_AW  EX-stage destination
- ex_regwrite  in  1  EX instruction writes a register
- ex_memread  in  1  EX instruction is a load (DatatoReg=01)
- mem_rd  in  REG_AW  MEM-stage destination
- mem_regwrite  in  1  MEM instruction writes a register
- ex_branch_taken  in  1  branch/jump resolved taken in EX
- md_start  in  1  mult/div issued in EX this cycle
- fwd_a  out  2  operand-A mux select, valid during EX
- fwd_b  out  2  operand-B mux select, valid during EX
- pc_stall  out  1  hold PC
- ifid_stall  out  1  hold IF/ID
- ifid_flush  out  1  clear IF/ID to bubble
- idex_flush  out  1  load bubble into ID/EX
- md_busy  out  1  mult/div unit busy

Behaviour:
- Interface:
  - Single clock clk.
  - Reset rst is synchronous and active-high.
- Reset values:
  - fwd_a = fwd_b = 2'b00.
  - All stall/flush outputs 0, md_busy 0.
  - State RUN, md counter 0.
- Forwarding:
  - Computed from ID-stage fields, registered at the clock edge, so fwd_a/fwd_b are valid in the cycle the instruction sits in EX (1-cycle latency).
  - For operand A (B identical with rt/id_use_rt):
    - 01 if ex_regwrite && ex_rd!=0 && ex_rd==id_rs && !ex_memread.
    - Else 10 if mem_regwrite && mem_rd!=0 && mem_rd==id_rs.
    - Else 00.
  - EX match has priority over MEM match.
  - Register 0 is never forwarded.
  - When id_use_rs=0, select 00.
  - When ID/EX holds or flushes, registered selects load 00.
- State machine (RUN, LOAD_STALL, MD_WAIT), stall outputs combinational from state and inputs:
  - RUN:
    - Load-use hazard: ex_memread && ex_rd!=0 && ex_rd matches a used ID source.
    - On load-use: pc_stall=ifid_stall=idex_flush=1 this cycle, go to LOAD_STALL.
    - Else if id_use_hilo && md_busy: same stall outputs, go to MD_WAIT.
  - LOAD_STALL:
    - Exactly one bubble; no stall outputs.
    - Forwarding recomputed; the load is now in MEM, so the select is 10.
    - Return to RUN next cycle.
  - MD_WAIT:
    - Stall outputs asserted while md_busy.
    - Return to RUN in the cycle the counter reaches 0; stall outputs 0 in that cycle.
- Mult/div counter:
  - md_start loads MD_LATENCY-1.
  - Decrements each cycle while nonzero.
  - md_busy = (counter != 0).
  - md_start while busy reloads the counter (restart).
- Branch flush:
  - ex_branch_taken → ifid_flush=idex_flush=1 and pc_stall=ifid_stall=0 in the same cycle.
  - State forced to RUN; the stalled ID instruction is squashed.
  - Flush has priority over every stall.
  - The md counter is unaffected, since the issued mult/div is older than the branch.
- Reset mid-stall: the next edge returns all state and outputs to reset values.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined:
  - Adds outputs stall_cycles[31:0] and flush_count[31:0], reset to 0.
  - stall_cycles increments every cycle pc_stall=1.
  - flush_count increments every cycle ifid_flush=1.
  - Both wrap at 2^32.
- Undefined: ports and counters absent; other behaviour identical.

Decomposition:
- Shared package (pipe_pkg):
  - Forward-select constants FWD_REG=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10.
  - State encodings RUN/LOAD_STALL/MD_WAIT.
  - REG_AW default.
- Sub-module md_busy_ctr: counter, reload, busy flag.
- Forward comparison written once as a function, used for A and B.

Test Plan:
- add $3←EX (ex_rd=3, ex_regwrite=1), ID reads rs=3 → next cycle fwd_a=01; same with mem_rd=3 only → fwd_a=10; rd=0 in both → fwd_a=00.
- EX and MEM both write $5, ID rs=rt=5 → fwd_a=fwd_b=01.
- Load $4 in EX, ID reads rt=4 → one cycle of pc_stall=ifid_stall=idex_flush=1, then fwd_b=10 and no stall.
- md_start with MD_LATENCY=4, mfhi enters ID one cycle later → stall held until md_busy falls, exactly 3 stalled cycles total including the entry cycle.
- Load-use stall coinciding with ex_branch_taken=1 → ifid_flush=idex_flush=1, pc_stall=0, state RUN.
- rst asserted during MD_WAIT → next cycle all outputs 0, md_busy 0; with HAZARD_PERF_EN, counters 0.
